// File: rtl/riscv_dmem_responder_pkg.sv
// Shared memory-message definitions for the data/instruction memory responders.
// Contents: request type/len encodings, response field widths, the response
// record layout, and store byte-enable / lane-replication helpers.
package riscv_dmem_responder_pkg;

  localparam logic       TYPE_READ  = 1'b0;
  localparam logic       TYPE_WRITE = 1'b1;

  localparam logic [1:0] LEN_WORD   = 2'd0;
  localparam logic [1:0] LEN_BYTE   = 2'd1;
  localparam logic [1:0] LEN_HALF   = 2'd2;

  localparam int RESP_TYPE_W = 1;
  localparam int RESP_DATA_W = 32;
  localparam int RESP_W      = RESP_TYPE_W + RESP_DATA_W;

  typedef struct packed {
    logic                   msg_type;
    logic [RESP_DATA_W-1:0] data;
  } dmem_resp_t;

  // Byte lanes touched by a store. Reserved len 3 falls through to word.
  function automatic logic [3:0] store_byte_en(input logic [1:0] len,
                                               input logic [1:0] off);
    logic [3:0] be;
    case (len)
      LEN_BYTE: be = 4'b0001 << off;
      LEN_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data arrives in the low lanes; replicate it so every enabled lane
  // sees the right bytes regardless of offset.
  function automatic logic [31:0] store_lane_data(input logic [1:0]  len,
                                                  input logic [31:0] data);
    logic [31:0] d;
    case (len)
      LEN_BYTE: d = {4{data[7:0]}};
      LEN_HALF: d = {2{data[15:0]}};
      default:  d = data;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_dmem_resp_queue.sv
// Small synchronous FIFO holding formatted memory responses.
// Ports:
//   clk, reset            clock, async active-low clear of pointers/count
//   push, push_data       enqueue (honoured when full if pop frees a slot)
//   pop                   dequeue the head (ignored when empty)
//   head_data             current head entry
//   full, empty           occupancy flags
module riscv_dmem_resp_queue
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [RESP_W-1:0] push_data,
  input  logic              pop,
  output logic [RESP_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [RESP_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign do_pop    = pop && !empty;
  // When full, the head slot is being read out this cycle, so the write into
  // that same slot at the edge is safe.
  assign do_push   = push && (!full || do_pop);
  assign head_data = entries[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder used as the target memory in core simulation.
// Requests are performed on an internal word array at the accept edge; the
// formatted response travels through a fixed delay pipe into an in-order
// response FIFO that the consumer drains under backpressure.
// Ports:
//   clk, reset                  clock, async active-low reset
//   memreq_val / memreq_rdy     request handshake
//   memreq_msg_type/len/addr/data  request fields (type 1 = write)
//   memresp_val / memresp_rdy   response handshake
//   memresp_msg_type/data       response fields (data 0 for writes)
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_msg_type,
  input  logic [1:0]  memreq_msg_len,
  input  logic [31:0] memreq_msg_addr,
  input  logic [31:0] memreq_msg_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_msg_type,
  output logic [31:0] memresp_msg_data
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_OUT = LATENCY + 1;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              req_fire;
  logic              resp_fire;
  logic [CNT_W-1:0]  out_cnt;
  dmem_resp_t        resp_new;
  logic              pipe_out_val;
  logic [RESP_W-1:0] pipe_out_msg;
  logic [RESP_W-1:0] q_head;
  logic              q_empty;
  logic              unused_q_full;
  logic              unused_addr_hi;

  // Upper address bits alias by design.
  assign unused_addr_hi = ^memreq_msg_addr[31:IDX_W+2];

  assign idx     = memreq_msg_addr[IDX_W+1:2];
  assign off     = memreq_msg_addr[1:0];
  assign rd_word = mem[idx];

  assign memreq_rdy = reset && (out_cnt < MAX_OUT_C);
  assign req_fire   = memreq_val && memreq_rdy;
  assign resp_fire  = memresp_val && memresp_rdy;

  assign wr_be   = store_byte_en(memreq_msg_len, off);
  assign wr_data = store_lane_data(memreq_msg_len, memreq_msg_data);

  // Loads are zero-filled in the low lanes; the core does the extension.
  always_comb begin
    ld_data = rd_word;
    case (memreq_msg_len)
      LEN_BYTE: ld_data = {24'b0, rd_word[{off, 3'b000} +: 8]};
      LEN_HALF: ld_data = {16'b0, off[1] ? rd_word[31:16] : rd_word[15:0]};
      default:  ld_data = rd_word;
    endcase
  end

  always_comb begin
    resp_new.msg_type = memreq_msg_type;
    resp_new.data     = (memreq_msg_type == TYPE_WRITE) ? 32'b0 : ld_data;
  end

  // Array has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (req_fire && (memreq_msg_type == TYPE_WRITE)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Delay pipe of LATENCY-1 stages; never stalls since out_cnt keeps the
  // FIFO from overflowing.
  if (LATENCY > 1) begin : g_pipe
    localparam int STAGES = LATENCY - 1;
    logic [STAGES-1:0] val_q;
    logic [RESP_W-1:0] msg_q [STAGES];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= '0;
      end else begin
        val_q[0] <= req_fire;
        for (int s = 1; s < STAGES; s++) val_q[s] <= val_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      msg_q[0] <= resp_new;
      for (int s = 1; s < STAGES; s++) msg_q[s] <= msg_q[s-1];
    end

    assign pipe_out_val = val_q[STAGES-1];
    assign pipe_out_msg = msg_q[STAGES-1];
  end else begin : g_nopipe
    assign pipe_out_val = req_fire;
    assign pipe_out_msg = resp_new;
  end

  riscv_dmem_resp_queue #(
    .DEPTH(MAX_OUT)
  ) u_resp_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_out_val),
    .push_data(pipe_out_msg),
    .pop      (memresp_rdy),
    .head_data(q_head),
    .full     (unused_q_full),
    .empty    (q_empty)
  );

  assign memresp_val      = !q_empty;
  assign memresp_msg_type = q_head[RESP_W-1];
  assign memresp_msg_data = q_head[RESP_DATA_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
module tb_riscv_dmem_responder;
  import riscv_dmem_responder_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_msg_type;
  logic [1:0]  memreq_msg_len;
  logic [31:0] memreq_msg_addr;
  logic [31:0] memreq_msg_data;
  logic        memresp_val;
  logic        memresp_rdy;
  logic        memresp_msg_type;
  logic [31:0] memresp_msg_data;

  int chk  = 0;
  int errs = 0;
  int cyc  = 0;

  logic [32:0] sb[$];
  int          pop_cyc[$];

  riscv_dmem_responder #(.LATENCY(LAT), .DEPTH(1024)) dut (
    .clk             (clk),
    .reset           (reset),
    .memreq_val      (memreq_val),
    .memreq_rdy      (memreq_rdy),
    .memreq_msg_type (memreq_msg_type),
    .memreq_msg_len  (memreq_msg_len),
    .memreq_msg_addr (memreq_msg_addr),
    .memreq_msg_data (memreq_msg_data),
    .memresp_val     (memresp_val),
    .memresp_rdy     (memresp_rdy),
    .memresp_msg_type(memresp_msg_type),
    .memresp_msg_data(memresp_msg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every response fire against the scoreboard head and
  // checks the head holds still while stalled.
  initial begin
    logic        stall_prev;
    logic [32:0] prev_head;
    logic [32:0] exp;
    stall_prev = 1'b0;
    prev_head  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("resp_stable", {memresp_msg_type, memresp_msg_data}, prev_head);
        if (memresp_val && memresp_rdy) begin
          if (sb.size() == 0) begin
            chk++;
            errs++;
            $display("FAIL unexpected_resp actual=%h required=none",
                     {memresp_msg_type, memresp_msg_data});
          end else begin
            exp = sb.pop_front();
            check("resp_msg", {memresp_msg_type, memresp_msg_data}, exp);
            pop_cyc.push_back(cyc);
          end
        end
        stall_prev = memresp_val && !memresp_rdy;
        prev_head  = {memresp_msg_type, memresp_msg_data};
      end
    end
  end

  task automatic send(input logic t, input logic [1:0] len, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_data,
                      output int acc, output int waited);
    @(negedge clk);
    memreq_val      = 1'b1;
    memreq_msg_type = t;
    memreq_msg_len  = len;
    memreq_msg_addr = addr;
    memreq_msg_data = wdata;
    waited = 0;
    while (!memreq_rdy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!memreq_rdy) begin
      chk++;
      errs++;
      $display("FAIL accept_timeout actual=rdy0 required=rdy1");
      acc = -1;
      memreq_val = 1'b0;
    end else begin
      sb.push_back({t, exp_data});
      acc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic idle_drain();
    int n;
    @(negedge clk);
    memreq_val = 1'b0;
    n = 0;
    while ((sb.size() != 0 || memresp_val) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk++;
      errs++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc, w, acc0, n_acc, w_sum;

    reset           = 1'b0;
    memreq_val      = 1'b1;
    memreq_msg_type = TYPE_READ;
    memreq_msg_len  = LEN_WORD;
    memreq_msg_addr = 32'h0;
    memreq_msg_data = 32'h0;
    memresp_rdy     = 1'b1;

    // Test 1: held in reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_req_rdy", memreq_rdy, 0);
      check("rst_resp_val", memresp_val, 0);
    end
    memreq_val = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", memreq_rdy, 1);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_resp_val", memresp_val, 0);
    end

    // Test 2: write then read, latency
    pop_cyc.delete();
    send(TYPE_WRITE, LEN_WORD, 32'h100, 32'hDEADBEEF, 32'h0, acc0, w);
    send(TYPE_READ,  LEN_WORD, 32'h100, 32'h0, 32'hDEADBEEF, acc, w);
    idle_drain();
    check("t2_npop", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) begin
      check("t2_lat_wr", pop_cyc[0], acc0 + LAT - 1);
      check("t2_lat_rd", pop_cyc[1], acc0 + LAT);
    end

    // Test 3: subword stores and loads
    send(TYPE_WRITE, LEN_BYTE, 32'h103, 32'h000000AB, 32'h0, acc, w);
    send(TYPE_READ,  LEN_WORD, 32'h100, 32'h0, 32'hABADBEEF, acc, w);
    send(TYPE_READ,  LEN_BYTE, 32'h103, 32'h0, 32'h000000AB, acc, w);
    send(TYPE_READ,  LEN_HALF, 32'h102, 32'h0, 32'h0000ABAD, acc, w);
    send(TYPE_READ,  LEN_HALF, 32'h101, 32'h0, 32'h0000BEEF, acc, w);
    send(TYPE_READ,  LEN_BYTE, 32'h101, 32'h0, 32'h000000BE, acc, w);
    send(TYPE_WRITE, LEN_WORD, 32'h208, 32'h11223344, 32'h0, acc, w);
    send(TYPE_WRITE, LEN_HALF, 32'h20B, 32'hFFFF1234, 32'h0, acc, w);
    send(TYPE_READ,  LEN_WORD, 32'h208, 32'h0, 32'h12343344, acc, w);
    send(TYPE_READ,  2'd3,     32'h208, 32'h0, 32'h12343344, acc, w);
    idle_drain();

    // Test 4: backpressure and outstanding cap
    @(negedge clk);
    memresp_rdy     = 1'b0;
    memreq_val      = 1'b1;
    memreq_msg_type = TYPE_READ;
    memreq_msg_len  = LEN_WORD;
    memreq_msg_addr = 32'h100;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (memreq_rdy) begin
        sb.push_back({TYPE_READ, 32'hABADBEEF});
        n_acc++;
      end
      @(negedge clk);
    end
    memreq_val = 1'b0;
    check("t4_n_accepted", n_acc, LAT + 1);
    check("t4_rdy_capped", memreq_rdy, 0);
    pop_cyc.delete();
    memresp_rdy = 1'b1;
    @(negedge clk);
    check("t4_rdy_reassert", memreq_rdy, 1);
    idle_drain();
    check("t4_npop", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("t4_consec1", pop_cyc[1], pop_cyc[0] + 1);
      check("t4_consec2", pop_cyc[2], pop_cyc[0] + 2);
    end

    // Test 5: full throughput and aliasing
    for (int i = 0; i < 8; i++)
      send(TYPE_WRITE, LEN_WORD, 32'(4 * i), 32'h10000000 + 32'(i), 32'h0, acc, w);
    idle_drain();
    pop_cyc.delete();
    w_sum = 0;
    for (int i = 0; i < 8; i++) begin
      send(TYPE_READ, LEN_WORD, 32'(4 * i), 32'h0, 32'h10000000 + 32'(i), acc, w);
      if (i == 0) acc0 = acc;
      w_sum += w;
    end
    idle_drain();
    check("t5_no_stall", w_sum, 0);
    check("t5_npop", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      check("t5_first_lat", pop_cyc[0], acc0 + LAT - 1);
      check("t5_last_consec", pop_cyc[7], pop_cyc[0] + 7);
    end
    send(TYPE_READ, LEN_WORD, 32'h1000, 32'h0, 32'h10000000, acc, w);
    idle_drain();

    // Test 6: reset with reads in flight
    send(TYPE_READ, LEN_WORD, 32'h100, 32'h0, 32'hABADBEEF, acc, w);
    send(TYPE_READ, LEN_WORD, 32'h100, 32'h0, 32'hABADBEEF, acc, w);
    memreq_val = 1'b0;
    #2;
    check("t6_val_before_rst", memresp_val, 1);
    reset = 1'b0;
    #1;
    check("t6_val_async_drop", memresp_val, 0);
    check("t6_rdy_in_rst", memreq_rdy, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t6_no_stale", memresp_val, 0);
    end
    send(TYPE_READ, LEN_WORD, 32'h100, 32'h0, 32'hABADBEEF, acc, w);
    idle_drain();

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
